// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready handshake, stall, flush with kill-masked bubble,
// optional skid entry so upstream ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int                 CTRL_W    = 16,
  parameter int                 DATA_W    = 160,
  parameter logic [CTRL_W-1:0]  KILL_MASK = {CTRL_W{1'b1}},
  parameter bit                 SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  // Encoding equals the number of held entries, so o_count is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                m_valid_q;
  logic                ready_q;
  logic [CTRL_W-1:0]   m_ctrl_q, s_ctrl_q;
  logic [DATA_W-1:0]   m_data_q, s_data_q;

  logic                accept, drain;
  logic                load_m_in, load_m_skid, load_s;

  assign o_ready = SKID ? ready_q : (!m_valid_q || i_ready);
  assign accept  = i_valid && o_ready;
  assign drain   = m_valid_q && i_ready;

  // NOTE: every output of a combinational block gets a default first, otherwise paths
  // that do not assign it infer a latch.
  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_m_in = 1'b1;
          end
        end
        ONE: begin
          unique case ({accept, drain})
            2'b11: load_m_in = 1'b1;
            2'b10: begin
              // Without a skid entry o_ready already implies i_ready, so this is unreachable.
              if (SKID) begin
                state_d = FULL;
                load_s  = 1'b1;
              end
            end
            2'b01:   state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          if (drain) begin
            state_d     = ONE;
            load_m_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      m_valid_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      m_valid_q <= (state_d != EMPTY);
      ready_q   <= (state_d != FULL);
    end
  end

  // NOTE: the payload registers are reset too, because o_data must read 0 out of reset;
  // they are wide, but they are ordinary flops, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      // Flush keeps the data but zeroes the killable control bits, leaving a clean bubble.
      if (i_flush) begin
        m_ctrl_q <= m_ctrl_q & ~KILL_MASK;
      end else if (load_m_in) begin
        m_ctrl_q <= i_ctrl;
        m_data_q <= i_data;
      end else if (load_m_skid) begin
        m_ctrl_q <= s_ctrl_q;
        m_data_q <= s_data_q;
      end
      if (load_s) begin
        s_ctrl_q <= i_ctrl;
        s_data_q <= i_data;
      end
    end
  end

  assign o_valid = m_valid_q;
  assign o_ctrl  = m_valid_q ? m_ctrl_q : (m_ctrl_q & ~KILL_MASK);
  assign o_data  = m_data_q;
  assign o_count = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance with a narrow kill mask and a
// SKID=0 instance with the default mask, sharing clock and reset.
module tb_pipe_stage_reg;

  typedef logic [159:0] word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic          a_i_valid, a_o_ready, a_i_flush, a_o_valid, a_i_ready;
  logic [15:0]   a_i_ctrl, a_o_ctrl;
  logic [159:0]  a_i_data, a_o_data;
  logic [1:0]    a_o_count;

  // SKID=0 instance
  logic          b_i_valid, b_o_ready, b_i_flush, b_o_valid, b_i_ready;
  logic [15:0]   b_i_ctrl, b_o_ctrl;
  logic [159:0]  b_i_data, b_o_data;
  logic [1:0]    b_o_count;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .KILL_MASK(16'h0003), .SKID(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .i_valid(a_i_valid), .o_ready(a_o_ready), .i_ctrl(a_i_ctrl), .i_data(a_i_data),
    .i_flush(a_i_flush), .o_valid(a_o_valid), .i_ready(a_i_ready),
    .o_ctrl(a_o_ctrl), .o_data(a_o_data), .o_count(a_o_count)
  );

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .i_valid(b_i_valid), .o_ready(b_o_ready), .i_ctrl(b_i_ctrl), .i_data(b_i_data),
    .i_flush(b_i_flush), .o_valid(b_o_valid), .i_ready(b_i_ready),
    .o_ctrl(b_o_ctrl), .o_data(b_o_data), .o_count(b_o_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input int cnt, input logic rdy,
                         input word_t data);
    check({tag, ".valid"}, word_t'(a_o_valid), word_t'(v));
    check({tag, ".count"}, word_t'(a_o_count), word_t'(cnt));
    check({tag, ".ready"}, word_t'(a_o_ready), word_t'(rdy));
    check({tag, ".data"},  a_o_data, data);
  endtask

  initial begin
    reset = 1'b1;
    a_i_valid = 1'b0; a_i_flush = 1'b0; a_i_ready = 1'b0; a_i_ctrl = '0; a_i_data = '0;
    b_i_valid = 1'b0; b_i_flush = 1'b0; b_i_ready = 1'b0; b_i_ctrl = '0; b_i_data = '0;
    #3;
    check_a("rst_a", 1'b0, 0, 1'b1, 0);
    check("rst_a.ctrl", word_t'(a_o_ctrl), 0);
    check("rst_b.ready", word_t'(b_o_ready), 1);
    check("rst_b.count", word_t'(b_o_count), 0);
    #9 reset = 1'b0;

    // Streaming 1..10 with i_ready held high: count stays at one entry.
    a_i_ready = 1'b1;
    a_i_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      a_i_data = word_t'(k);
      a_i_ctrl = 16'(k);
      tick();
      check_a($sformatf("stream%0d", k), 1'b1, 1, 1'b1, word_t'(k));
    end
    a_i_valid = 1'b0;
    tick();
    check_a("stream_end", 1'b0, 0, 1'b1, 10);

    // Stall into the skid entry.
    a_i_ready = 1'b0;
    a_i_valid = 1'b1; a_i_data = 'hA; a_i_ctrl = 16'h00A0;
    tick();
    check_a("skid_m", 1'b1, 1, 1'b1, 'hA);
    a_i_data = 'hB; a_i_ctrl = 16'h00B0;
    tick();
    check_a("skid_full", 1'b1, 2, 1'b0, 'hA);
    a_i_data = 'hC;
    tick();
    check_a("skid_hold", 1'b1, 2, 1'b0, 'hA);
    a_i_valid = 1'b0;
    a_i_ready = 1'b1;
    #1 check("skid_ready_reg", word_t'(a_o_ready), 0);
    tick();
    check_a("skid_drain1", 1'b1, 1, 1'b1, 'hB);
    check("skid_ctrl1", word_t'(a_o_ctrl), 'h00B0);
    tick();
    check_a("skid_drain2", 1'b0, 0, 1'b1, 'hB);
    check("skid_empty_ctrl", word_t'(a_o_ctrl), 'h00B0 & ~'h3);

    // Flush bubble: killable bits drop, data is kept, input dropped.
    a_i_ready = 1'b0;
    a_i_valid = 1'b1; a_i_ctrl = 16'hFFFF; a_i_data = 'h55;
    tick();
    check("fl_load_ctrl", word_t'(a_o_ctrl), 'hFFFF);
    a_i_flush = 1'b1; a_i_ctrl = 16'h1234; a_i_data = 'h66;
    tick();
    check_a("flush", 1'b0, 0, 1'b1, 'h55);
    check("flush.ctrl", word_t'(a_o_ctrl), 'hFFFC);
    a_i_flush = 1'b0; a_i_valid = 1'b0;
    tick();
    check_a("flush_idle", 1'b0, 0, 1'b1, 'h55);

    // Flush while FULL, then a lone entry follows.
    a_i_valid = 1'b1; a_i_data = 'h1; a_i_ctrl = 16'h0001;
    tick();
    a_i_data = 'h2; a_i_ctrl = 16'h0002;
    tick();
    check("ff_count", word_t'(a_o_count), 2);
    a_i_flush = 1'b1; a_i_data = 'h3;
    tick();
    check_a("ff_flush", 1'b0, 0, 1'b1, 'h1);
    a_i_flush = 1'b0; a_i_data = 'h7; a_i_ctrl = 16'h0007;
    tick();
    check_a("ff_accept7", 1'b1, 1, 1'b1, 'h7);
    a_i_valid = 1'b0; a_i_ready = 1'b1;
    tick();
    check_a("ff_drain7", 1'b0, 0, 1'b1, 'h7);

    // Flush together with a drain still empties the stage.
    a_i_valid = 1'b1; a_i_data = 'h9; a_i_ready = 1'b0;
    tick();
    a_i_valid = 1'b0; a_i_ready = 1'b1; a_i_flush = 1'b1;
    tick();
    a_i_flush = 1'b0;
    check_a("flush_drain", 1'b0, 0, 1'b1, 'h9);

    // Asynchronous reset mid-cycle with both entries loaded.
    a_i_ready = 1'b0; a_i_valid = 1'b1; a_i_ctrl = 16'hFFFF; a_i_data = 'h11;
    tick();
    a_i_data = 'h22;
    tick();
    a_i_valid = 1'b0;
    check("pre_rst_count", word_t'(a_o_count), 2);
    #1 reset = 1'b1;
    #1;
    check_a("async_rst", 1'b0, 0, 1'b1, 0);
    check("async_rst.ctrl", word_t'(a_o_ctrl), 0);
    #1 reset = 1'b0;
    a_i_valid = 1'b1; a_i_data = 'h33; a_i_ctrl = 16'h0033;
    tick();
    check_a("post_rst", 1'b1, 1, 1'b1, 'h33);
    a_i_valid = 1'b0;

    // SKID=0: combinational ready and single-edge replacement.
    b_i_valid = 1'b1; b_i_data = 'h10; b_i_ctrl = 16'h0010; b_i_ready = 1'b0;
    tick();
    check("b_load.count", word_t'(b_o_count), 1);
    check("b_stall.ready", word_t'(b_o_ready), 0);
    b_i_ready = 1'b1;
    #1 check("b_comb.ready", word_t'(b_o_ready), 1);
    b_i_data = 'h20; b_i_ctrl = 16'h0020;
    tick();
    check("b_replace.data", b_o_data, 'h20);
    check("b_replace.count", word_t'(b_o_count), 1);
    b_i_ready = 1'b0; b_i_data = 'h30;
    tick();
    check("b_hold.data", b_o_data, 'h20);
    b_i_valid = 1'b0; b_i_ready = 1'b1;
    tick();
    check("b_empty.valid", word_t'(b_o_valid), 0);
    check("b_empty.ctrl", word_t'(b_o_ctrl), 0);
    check("b_empty.data", b_o_data, 'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register that replaces the hand-written per-stage registers (ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control bundle and a data bundle between stages under a valid/ready handshake, supports stall via downstream back-pressure, and supports flush with bubble insertion: kill-masked control bits read as 0 when empty or flushed. An optional skid entry gives a fully registered upstream ready, so back-pressure never forms a combinational path across stages.

## Interface
Parameters:
- CTRL_W, 16, width of control bundle (reg_write, mem_write, branch, alu_op, ...)
- DATA_W, 160, width of data bundle (pc_4, operands, immediates, register indices, ...)
- KILL_MASK, {CTRL_W{1'b1}}, control bits forced to 0 on o_ctrl whenever the stage holds no valid entry
- SKID, 1, 1 = two-entry stage with registered o_ready; 0 = single entry with combinational o_ready

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clock clk
- i_valid  in  1  upstream offers an entry
- o_ready  out  1  stage can accept an entry this cycle
- i_ctrl  in  CTRL_W  upstream control bundle
- i_data  in  DATA_W  upstream data bundle
- i_flush  in  1  synchronous flush: discard all held entries and the current input
- o_valid  out  1  stage presents a valid entry
- i_ready  in  1  downstream accepts this cycle
- o_ctrl  out  CTRL_W  presented control bundle, kill-masked when invalid
- o_data  out  DATA_W  presented data bundle
- o_count  out  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Storage: main entry M (drives outputs) and, if SKID=1, skid entry S. Each has a valid bit plus ctrl and data registers.
- Transfers: accept = i_valid & o_ready; drain = o_valid & i_ready.
- o_ready:
  - SKID=1: equals !S_valid, taken from a register.
  - SKID=0: equals !M_valid | i_ready.
- States, with SKID=1:
  - EMPTY (o_count=0): accept loads M and moves to ONE.
  - ONE (o_count=1):
    - accept & drain: M <= input, stay in ONE.
    - accept & !drain: S <= input, move to FULL.
    - !accept & drain: move to EMPTY.
    - Otherwise hold.
  - FULL (o_count=2): o_ready=0. Drain moves S to M and goes to ONE. Otherwise hold.
- States, with SKID=0: EMPTY and ONE only. In ONE, accept & drain replaces M.
- Flush:
  - i_flush=1 at a clock edge clears M_valid and S_valid and drops any accept in that cycle. Next state is EMPTY.
  - Data registers are not cleared on flush.
  - M_ctrl bits in KILL_MASK are cleared, so the bubble has reg_write/mem_write = 0.
- Output masking: o_ctrl = M_valid ? M_ctrl : (M_ctrl & ~KILL_MASK). o_data = M_data, unconditionally.
- Ordering: strict FIFO. No entry is duplicated or lost except by flush.
- Reset values:
  - o_valid=0, o_ctrl=0, o_data=0, o_count=0.
  - o_ready=1 for both SKID values.
  - All internal valid, ctrl and data registers are 0.
- Reset mid-operation: all entries are discarded immediately (asynchronous). The first accept is possible on the first rising edge after reset deasserts.

## Timing
- Latency: an entry accepted at edge N is visible on o_valid/o_ctrl/o_data after edge N.
- Throughput: 1 entry/cycle sustained while i_ready=1.
- Timing paths:
  - SKID=1: o_ready, o_valid, o_ctrl and o_data are register outputs. The only logic on o_ctrl is the kill-mask AND.
  - SKID=0: o_ready has a combinational path from i_ready.
- Once o_valid=1, o_ctrl and o_data stay stable until drain or flush. Upstream may change i_* freely while o_ready=0.
- Simultaneous events:
  - flush + accept: flush wins.
  - flush + drain: the drained entry counts as delivered downstream, and the stage is still emptied.
  - FULL + drain: o_ready returns to 1 on the following cycle, not the same cycle.

## Test plan
- Reset: assert reset asynchronously mid-cycle with M and S loaded -> o_valid=0, o_ctrl=0, o_data=0, o_count=0, o_ready=1 immediately, without waiting for a clock edge.
- Streaming: SKID=1, i_ready=1, i_valid=1 with data 1,2,3...10 on consecutive cycles -> o_data = 1..10 on consecutive cycles starting one cycle after the first accept; o_count stays 1.
- Stall/skid: after accepting 0xA, drop i_ready with i_valid=1 and data 0xB -> o_count=2, o_ready=0, o_data=0xA held. Raise i_ready -> 0xA then 0xB delivered in order, and o_ready=1 one cycle after the first drain.
- Flush bubble: KILL_MASK=16'h0003, M holds ctrl=16'hFFFF and data=0x55; pulse i_flush with i_valid=1 -> next cycle o_valid=0, o_ctrl=16'hFFFC, o_data=0x55, o_count=0, and the input is dropped.
- Flush while FULL: o_count=2, i_flush=1, i_ready=0 -> o_count=0, o_ready=1 next cycle; the subsequent accept of 0x7 appears alone on o_data.
- SKID=0: hold i_ready=0 with M valid -> o_ready=0 in the same cycle. Raise i_ready with i_valid=1 -> replacement in one edge, o_count stays 1.
